// File: rtl/secboot_pkg.sv
// Shared encodings and hash helpers for the secure-boot sequencer.
package secboot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAIL  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        FC_NONE       = 3'd0,
        FC_TIMEOUT    = 3'd1,
        FC_ROLLBACK   = 3'd2,
        FC_DIGEST     = 3'd3,
        FC_ALT_DIGEST = 3'd4
    } fail_code_e;

    localparam logic [31:0] IV_BASE = 32'h6A09_E667;
    localparam int          ROT_AMT = 5;

    function automatic logic [31:0] rotl(input logic [31:0] x);
        return (x << ROT_AMT) | (x >> (32 - ROT_AMT));
    endfunction

    function automatic logic [31:0] lane_iv(input int j);
        return IV_BASE ^ 32'(j);
    endfunction

endpackage

// File: rtl/secboot_hash_acc.sv
// Digest lane accumulator: IV init, rotate-xor word update, full compare.
module secboot_hash_acc
    import secboot_pkg::*;
#(
    parameter int HASH_LANES = 8,
    parameter int WW         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_i,
    input  logic                     upd_i,
    input  logic [WW-1:0]            word_i,
    input  logic [31:0]              data_i,
    input  logic [HASH_LANES*32-1:0] digest_i,
    output logic                     match_o
);

    logic [HASH_LANES-1:0][31:0] lanes_q, lanes_d;

    always_comb begin
        lanes_d = lanes_q;
        for (int j = 0; j < HASH_LANES; j++) begin
            if (init_i) begin
                lanes_d[j] = lane_iv(j);
            end else if (upd_i && (int'(word_i) % HASH_LANES) == j) begin
                lanes_d[j] = rotl(lanes_q[j]) ^ data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < HASH_LANES; j++) begin
                lanes_q[j] <= lane_iv(j);
            end
        end else begin
            lanes_q <= lanes_d;
        end
    end

    assign match_o = (lanes_q == digest_i);

endmodule

// File: rtl/secure_boot_seq.sv
// Multi-image secure-boot sequencer: fetch, hash, rollback and digest checks.
// Define SECBOOT_ALT_BANK_EN to retry a digest mismatch once from the alt bank.
module secure_boot_seq
    import secboot_pkg::*;
#(
    parameter int          NUM_IMG     = 2,
    parameter int          IMG_WORDS   = 256,
    parameter int          HASH_LANES  = 8,
    parameter logic [31:0] IMG_BASE    = 32'h1000_0000,
    parameter logic [31:0] IMG_STRIDE  = 32'h0000_1000,
    parameter int          TIMEOUT_CYC = 64,
    localparam int         IW = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
`ifdef SECBOOT_ALT_BANK_EN
    ,
    parameter logic [31:0] ALT_OFFSET  = 32'h0010_0000
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     flash_req,
    output logic [31:0]              flash_addr,
    input  logic                     flash_ack,
    input  logic [31:0]              flash_rdata,
    output logic [IW-1:0]            otp_idx,
    input  logic [HASH_LANES*32-1:0] otp_digest,
    input  logic [31:0]              otp_min_ver,
    output logic [2:0]               boot_stage,
    output logic [NUM_IMG-1:0]       verified_mask,
    output logic                     boot_ready,
    output logic                     violation,
    output logic [2:0]               fail_code
);

    localparam int WW = $clog2(IMG_WORDS);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e             state_q, state_d;
    logic [IW-1:0]      img_q, img_d;
    logic [WW-1:0]      word_q, word_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [NUM_IMG-1:0] mask_q, mask_d;
    fail_code_e         code_q, code_d;
    logic               hash_init, hash_upd, hash_match;
    logic [31:0]        addr;
`ifdef SECBOOT_ALT_BANK_EN
    logic               alt_q, alt_d;
`endif

    always_comb begin
        state_d   = state_q;
        img_d     = img_q;
        word_d    = word_q;
        tmo_d     = tmo_q;
        mask_d    = mask_q;
        code_d    = code_q;
        hash_init = 1'b0;
        hash_upd  = 1'b0;
`ifdef SECBOOT_ALT_BANK_EN
        alt_d     = alt_q;
`endif
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flash_ack) begin
                    hash_upd = 1'b1;
                    if (word_q == '0 && flash_rdata < otp_min_ver) begin
                        code_d  = FC_ROLLBACK;
                        state_d = ST_FAIL;
                    end else if (word_q == WW'(IMG_WORDS - 1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        word_d  = word_q + WW'(1);
                        state_d = ST_REQ;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    code_d  = FC_TIMEOUT;
                    state_d = ST_FAIL;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_CHECK: begin
                if (hash_match) begin
                    mask_d  = mask_q | (NUM_IMG'(1) << img_q);
                    state_d = ST_NEXT;
                end else begin
`ifdef SECBOOT_ALT_BANK_EN
                    if (!alt_q) begin
                        alt_d     = 1'b1;
                        hash_init = 1'b1;
                        word_d    = '0;
                        state_d   = ST_REQ;
                    end else begin
                        code_d  = FC_ALT_DIGEST;
                        state_d = ST_FAIL;
                    end
`else
                    code_d  = FC_DIGEST;
                    state_d = ST_FAIL;
`endif
                end
            end
            ST_NEXT: begin
                hash_init = 1'b1;
                word_d    = '0;
`ifdef SECBOOT_ALT_BANK_EN
                alt_d     = 1'b0;
`endif
                if (img_q == IW'(NUM_IMG - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    img_d   = img_q + IW'(1);
                    state_d = ST_REQ;
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_FAIL;
        endcase
        // A failed chain must never advertise partially verified images.
        if (state_d == ST_FAIL) mask_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            img_q   <= '0;
            word_q  <= '0;
            tmo_q   <= '0;
            mask_q  <= '0;
            code_q  <= FC_NONE;
`ifdef SECBOOT_ALT_BANK_EN
            alt_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            word_q  <= word_d;
            tmo_q   <= tmo_d;
            mask_q  <= mask_d;
            code_q  <= code_d;
`ifdef SECBOOT_ALT_BANK_EN
            alt_q   <= alt_d;
`endif
        end
    end

    always_comb begin
        addr = IMG_BASE + 32'(img_q) * IMG_STRIDE + (32'(word_q) << 2);
`ifdef SECBOOT_ALT_BANK_EN
        if (alt_q) addr = addr + ALT_OFFSET;
`endif
    end

    secboot_hash_acc #(
        .HASH_LANES(HASH_LANES),
        .WW        (WW)
    ) u_hash (
        .clk     (clk),
        .rst_n   (rst_n),
        .init_i  (hash_init),
        .upd_i   (hash_upd),
        .word_i  (word_q),
        .data_i  (flash_rdata),
        .digest_i(otp_digest),
        .match_o (hash_match)
    );

    assign flash_req     = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign flash_addr    = flash_req ? addr : '0;
    assign otp_idx       = img_q;
    assign boot_stage    = state_q;
    assign verified_mask = mask_q;
    assign boot_ready    = (state_q == ST_DONE);
    assign violation     = (state_q == ST_FAIL);
    assign fail_code     = code_q;

endmodule

// File: tb/tb_secure_boot_seq.sv
// Scoreboard bench for secure_boot_seq: flash/OTP model plus reference boot plan.
module tb_secure_boot_seq;

    localparam int          NI     = 2;
    localparam int          NW     = 16;
    localparam int          NL     = 8;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] STRIDE = 32'h0000_1000;
    localparam logic [31:0] ALTOFS = 32'h0010_0000;
    localparam logic [31:0] KEY    = 32'hB007_0001;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flash_req;
    logic [31:0]     flash_addr;
    logic            flash_ack = 1'b0;
    logic [31:0]     flash_rdata = '0;
    logic [0:0]      otp_idx;
    logic [NL*32-1:0] otp_digest;
    logic [31:0]     otp_min_ver;
    logic [2:0]      boot_stage;
    logic [NI-1:0]   verified_mask;
    logic            boot_ready;
    logic            violation;
    logic [2:0]      fail_code;

    logic [31:0]      ver_t  [NI];
    logic [31:0]      minv_t [NI];
    logic [NL*32-1:0] good_t [NI];
    int cimg = -1, cw = -1, himg = -1, hw = -1;
    bit stray = 0;

    typedef struct {
        logic [2:0]    stage;
        logic [NI-1:0] mask;
        logic          ready;
        logic          viol;
        logic [2:0]    code;
    } fin_t;

    logic [31:0] exp_addr[$];
    fin_t        exp_fin[$];
    bit          armed = 0;
    int          cyc = 0, last_req_cyc = 0, term_cyc = 0;
    int          n_pass = 0, n_tot = 0;

    secure_boot_seq #(
        .NUM_IMG  (NI),
        .IMG_WORDS(NW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flash_req    (flash_req),
        .flash_addr   (flash_addr),
        .flash_ack    (flash_ack),
        .flash_rdata  (flash_rdata),
        .otp_idx      (otp_idx),
        .otp_digest   (otp_digest),
        .otp_min_ver  (otp_min_ver),
        .boot_stage   (boot_stage),
        .verified_mask(verified_mask),
        .boot_ready   (boot_ready),
        .violation    (violation),
        .fail_code    (fail_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign otp_digest  = good_t[otp_idx];
    assign otp_min_ver = minv_t[otp_idx];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    endtask

    task automatic fail_now(string nm);
        n_tot++;
        $display("FAIL %s got=expired want=event", nm);
    endtask

    function automatic logic [31:0] addr_of(int img, int w, bit alt);
        return BASE + 32'(img) * STRIDE + 32'(4 * w) + (alt ? ALTOFS : 32'h0);
    endfunction

    // Flash contents: version word, then address-derived data.
    function automatic logic [31:0] word_data(int img, int w, bit alt, bit corr);
        logic [31:0] d;
        if (w == 0) return ver_t[img];
        d = addr_of(img, w, 1'b0) ^ KEY;
        if (corr && !alt && img == cimg && w == cw) d = d ^ 32'h0000_DEAD;
        return d;
    endfunction

    function automatic logic [NL*32-1:0] digest(int img, bit alt, bit corr);
        logic [31:0]      ln [NL];
        logic [31:0]      t;
        logic [NL*32-1:0] r;
        for (int j = 0; j < NL; j++) ln[j] = 32'h6A09_E667 ^ 32'(j);
        for (int w = 0; w < NW; w++) begin
            t = ln[w % NL];
            ln[w % NL] = {t[26:0], t[31:27]} ^ word_data(img, w, alt, corr);
        end
        for (int j = 0; j < NL; j++) r[j*32 +: 32] = ln[j];
        return r;
    endfunction

    // Reference boot: expected request addresses and final outcome.
    task automatic plan();
        int            code;
        logic [NI-1:0] mask;
        fin_t          f;
        code = 0;
        mask = '0;
        for (int i = 0; i < NI; i++) good_t[i] = digest(i, 1'b0, 1'b0);
        for (int i = 0; i < NI && code == 0; i++) begin
            for (int a = 0; a < 2 && code == 0; a++) begin
                for (int w = 0; w < NW; w++) begin
                    exp_addr.push_back(addr_of(i, w, a[0]));
                    if (a == 0 && i == himg && w == hw) begin
                        code = 1;
                        break;
                    end
                    if (w == 0 && ver_t[i] < minv_t[i]) begin
                        code = 2;
                        break;
                    end
                end
                if (code != 0) break;
                if (digest(i, a[0], 1'b1) == good_t[i]) begin
                    mask[i] = 1'b1;
                    break;
                end
`ifdef SECBOOT_ALT_BANK_EN
                if (a == 1) code = 4;
`else
                code = 3;
`endif
            end
        end
        if (code != 0) f = '{3'd7, '0, 1'b0, 1'b1, 3'(code)};
        else f = '{3'd5, mask, 1'b1, 1'b0, 3'd0};
        exp_fin.push_back(f);
    endtask

    // Flash model: ack three cycles after a request opens, plus stray acks.
    int          fm_cnt = 0;
    bit          fm_busy = 0;
    logic [31:0] fm_addr;
    always @(negedge clk) begin : flash_model
        int          img, w;
        bit          alt;
        logic [31:0] l;
        flash_ack = 1'b0;
        if (!rst_n) begin
            fm_busy = 0;
        end else if (flash_req) begin
            if (!fm_busy) begin
                fm_busy = 1;
                fm_cnt  = 0;
                fm_addr = flash_addr;
            end
            fm_cnt++;
            alt = (fm_addr & ALTOFS) != 0;
            l   = fm_addr & ~ALTOFS;
            img = int'((l - BASE) / STRIDE);
            w   = int'(((l - BASE) % STRIDE) / 4);
            if (fm_cnt == 3 && !(!alt && img == himg && w == hw)) begin
                flash_ack   = 1'b1;
                flash_rdata = word_data(img, w, alt, 1'b1);
                fm_busy     = 0;
            end
        end else begin
            fm_busy = 0;
        end
        if (!flash_ack && stray && rst_n &&
            (boot_stage inside {3'd1, 3'd3, 3'd4}) &&
            $urandom_range(0, 1) == 1) begin
            flash_ack   = 1'b1;
            flash_rdata = $urandom;
        end
    end

    // Monitor: pops expectations on each new request and on termination.
    bit          mon_prev_req = 0;
    logic [31:0] mon_prev_addr = '0;
    always @(posedge clk) begin : monitor
        logic [31:0] e;
        fin_t        f;
        #1;
        if (!rst_n) begin
            mon_prev_req = 0;
        end else begin
            if (flash_req && (!mon_prev_req || flash_addr != mon_prev_addr)) begin
                last_req_cyc = cyc;
                if (exp_addr.size() == 0) begin
                    chk("addr_extra", flash_addr, 64'hFFFF_FFFF_FFFF);
                end else begin
                    e = exp_addr.pop_front();
                    chk("addr", flash_addr, e);
                end
            end
            mon_prev_req  = flash_req;
            mon_prev_addr = flash_addr;
            if (armed && (boot_stage == 3'd5 || boot_stage == 3'd7)) begin
                armed    = 0;
                term_cyc = cyc;
                if (exp_fin.size() == 0) begin
                    fail_now("fin_missing");
                end else begin
                    f = exp_fin.pop_front();
                    chk("fin_stage", boot_stage, f.stage);
                    chk("fin_mask", verified_mask, f.mask);
                    chk("fin_ready", boot_ready, f.ready);
                    chk("fin_viol", violation, f.viol);
                    chk("fin_code", fail_code, f.code);
                end
            end
        end
    end

    task automatic set_default();
        ver_t[0]  = 32'd2;
        ver_t[1]  = 32'd2;
        minv_t[0] = 32'd1;
        minv_t[1] = 32'd1;
        cimg = -1; cw = -1; himg = -1; hw = -1;
        stray = 0;
    endtask

    task automatic check_reset_out(string tag);
        chk({tag, ":rst_out"},
            {boot_stage, verified_mask, boot_ready, violation, fail_code, flash_req}, 0);
        chk({tag, ":rst_addr"}, flash_addr, 0);
    endtask

    // Expects rst_n low on entry; leaves rst_n low on exit.
    task automatic run_boot(string tag);
        exp_addr.delete();
        exp_fin.delete();
        plan();
        @(negedge clk);
        check_reset_out(tag);
        armed = 1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk({tag, ":stage_req"}, {boot_stage, flash_req}, {3'd1, 1'b1});
        @(posedge clk); #1;
        chk({tag, ":stage_wait"}, boot_stage, 3'd2);
        for (int i = 0; i < 4000 && armed; i++) @(negedge clk);
        if (armed) begin
            fail_now({tag, ":no_terminal"});
            armed = 0;
        end
        repeat (8) @(negedge clk);
        chk({tag, ":req_quiet"}, flash_req, 0);
        chk({tag, ":addr_all"}, exp_addr.size(), 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        set_default();
        for (int i = 0; i < NI; i++) good_t[i] = '0;
        repeat (3) @(negedge clk);

        set_default();
        run_boot("good");

        set_default();
        ver_t[1] = 32'd0;
        run_boot("rollback");

        set_default();
        himg = 0;
        hw   = 5;
        run_boot("timeout");
        chk("tmo_latency", (term_cyc - last_req_cyc) inside {[64:66]}, 1);

        set_default();
        cimg = 0;
        cw   = 9;
        run_boot("corrupt");

        set_default();
        exp_addr.delete();
        exp_fin.delete();
        plan();
        exp_addr.delete();
        exp_fin.delete();
        for (int w = 0; w < NW; w++) exp_addr.push_back(addr_of(0, w, 1'b0));
        for (int w = 0; w < 8; w++) exp_addr.push_back(addr_of(1, w, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        begin : wait_abort
            bit hit;
            hit = 0;
            for (int i = 0; i < 2000 && !hit; i++) begin
                @(negedge clk);
                hit = flash_req && flash_addr == addr_of(1, 7, 1'b0);
            end
            if (!hit) fail_now("abort_wait");
        end
        rst_n = 1'b0;
        #1;
        chk("abort_out", {boot_stage, verified_mask, flash_req}, 0);
        chk("abort_addr_all", exp_addr.size(), 0);
        repeat (2) @(negedge clk);
        run_boot("resume");

        set_default();
        stray = 1;
        run_boot("stray");

        for (int r = 0; r < 5; r++) begin
            set_default();
            for (int i = 0; i < NI; i++) begin
                ver_t[i]  = 32'($urandom_range(0, 3));
                minv_t[i] = 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 1) begin
                cimg = int'($urandom_range(0, NI - 1));
                cw   = int'($urandom_range(1, NW - 1));
            end
            stray = $urandom_range(0, 1) == 1;
            run_boot("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
